// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous lines; a two-column register plus the
// freshly read column form the raw window. Out-of-frame taps are zeroed or
// clamped to the nearest edge pixel according to BORDER_MODE.
//
// state | meaning
// IDLE  | waiting for pixel (0,0) of a new frame
// FILL  | accepting pixels, no window complete yet
// RUN   | each accepted pixel completes one window
// FLUSH | input dropped, last IMG_W+1 windows generated one per clock
module matrix_3x3_gen #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int BORDER_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              dout_vld,
    output logic [DATA_W-1:0] matrix_11,
    output logic [DATA_W-1:0] matrix_12,
    output logic [DATA_W-1:0] matrix_13,
    output logic [DATA_W-1:0] matrix_21,
    output logic [DATA_W-1:0] matrix_22,
    output logic [DATA_W-1:0] matrix_23,
    output logic [DATA_W-1:0] matrix_31,
    output logic [DATA_W-1:0] matrix_32,
    output logic [DATA_W-1:0] matrix_33
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMG_W);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] in_row, out_row;
    logic [FW-1:0] flush_cnt;

    logic [DATA_W-1:0] line_1 [IMG_W];
    logic [DATA_W-1:0] line_2 [IMG_W];

    // Column vectors, index 0 = top row, 2 = bottom row.
    logic [2:0][DATA_W-1:0] col_a, col_b, col_new;
    logic [2:0][DATA_W-1:0] win_l, win_m, win_r;

    logic accept, emit, advance;
    logic in_last, fill_done, flush_done;
    logic top_ok, bot_ok, left_ok, right_ok;

    assign in_last    = (in_col == COL_LAST) && (in_row == ROW_LAST);
    assign fill_done  = (in_col == CW'(1)) && (in_row == RW'(1));
    assign flush_done = (flush_cnt == '0);
    assign busy       = (state == FLUSH);
    assign advance    = accept || (state == FLUSH);

    // The new column comes from the line buffers at the current input column;
    // during FLUSH there is no pixel, and the bottom tap is masked anyway.
    assign col_new = {(accept ? din : {DATA_W{1'b0}}), line_1[in_col], line_2[in_col]};

    assign top_ok   = (out_row != '0);
    assign bot_ok   = (out_row != ROW_LAST);
    assign left_ok  = (out_col != '0);
    assign right_ok = (out_col != COL_LAST);

    function automatic logic [2:0][DATA_W-1:0] fix_rows(input logic [2:0][DATA_W-1:0] col,
                                                        input logic t_ok,
                                                        input logic b_ok);
        logic [2:0][DATA_W-1:0] res;
        res = col;
        if (!t_ok) res[0] = (BORDER_MODE == 1) ? col[1] : {DATA_W{1'b0}};
        if (!b_ok) res[2] = (BORDER_MODE == 1) ? col[1] : {DATA_W{1'b0}};
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle strobes: accept a pixel, emit a window.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        case (state)
            IDLE: begin
                if (din_vld) begin
                    accept    = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (din_vld) begin
                    accept = 1'b1;
                    if (fill_done) begin
                        emit      = 1'b1;
                        state_nxt = in_last ? FLUSH : RUN;
                    end
                end
            end
            RUN: begin
                if (din_vld) begin
                    accept = 1'b1;
                    emit   = 1'b1;
                    if (in_last) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                emit = 1'b1;
                if (flush_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Border handling: rows first, then whole columns, so corners clamp on both axes.
    always_comb begin
        win_l = fix_rows(col_a, top_ok, bot_ok);
        win_m = fix_rows(col_b, top_ok, bot_ok);
        win_r = fix_rows(col_new, top_ok, bot_ok);
        if (!left_ok)  win_l = (BORDER_MODE == 1) ? win_m : '0;
        if (!right_ok) win_r = (BORDER_MODE == 1) ? win_m : '0;
    end

    // Line buffers: no reset needed, stale contents are always masked.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_2[in_col] <= line_1[in_col];
            line_1[in_col] <= din;
        end
    end

    // Position counters, flush timer, window shift and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col    <= '0;
            in_row    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            flush_cnt <= '0;
            col_a     <= '0;
            col_b     <= '0;
            dout_vld  <= 1'b0;
            matrix_11 <= '0;
            matrix_12 <= '0;
            matrix_13 <= '0;
            matrix_21 <= '0;
            matrix_22 <= '0;
            matrix_23 <= '0;
            matrix_31 <= '0;
            matrix_32 <= '0;
            matrix_33 <= '0;
        end else begin
            if (accept) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end else if (state == FLUSH) begin
                // Flush walks one virtual line past the frame, then parks at column 0.
                if (flush_done || (in_col == COL_LAST)) in_col <= '0;
                else                                    in_col <= in_col + 1'b1;
            end

            if (accept && in_last)                  flush_cnt <= FLUSH_LOAD;
            else if ((state == FLUSH) && !flush_done) flush_cnt <= flush_cnt - 1'b1;

            if (advance) begin
                col_a <= col_b;
                col_b <= col_new;
            end

            dout_vld <= emit;
            if (emit) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
                matrix_11 <= win_l[0];
                matrix_12 <= win_m[0];
                matrix_13 <= win_r[0];
                matrix_21 <= win_l[1];
                matrix_22 <= win_m[1];
                matrix_23 <= win_r[1];
                matrix_31 <= win_l[2];
                matrix_32 <= win_m[2];
                matrix_33 <= win_r[2];
            end
        end
    end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: two instances (zero and replicate borders) share
// one stimulus stream and are compared every cycle to a frame-level model.
module tb_matrix_3x3_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 8;

    localparam logic [71:0] C00_Z = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
    localparam logic [71:0] C00_R = {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6};
    localparam logic [71:0] C11   = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    localparam logic [71:0] C23_Z = {8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [71:0] C23_R = {8'd7, 8'd8, 8'd8, 8'd11, 8'd12, 8'd12, 8'd11, 8'd12, 8'd12};

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          din_vld = 1'b0;
    logic [DW-1:0] din     = '0;
    logic          busy0, busy1, vld0, vld1;
    logic [DW-1:0] m0 [9];
    logic [DW-1:0] m1 [9];
    logic [71:0]   win0, win1;

    matrix_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dut_zero (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
        .busy(busy0), .dout_vld(vld0),
        .matrix_11(m0[0]), .matrix_12(m0[1]), .matrix_13(m0[2]),
        .matrix_21(m0[3]), .matrix_22(m0[4]), .matrix_23(m0[5]),
        .matrix_31(m0[6]), .matrix_32(m0[7]), .matrix_33(m0[8])
    );

    matrix_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dut_repl (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
        .busy(busy1), .dout_vld(vld1),
        .matrix_11(m1[0]), .matrix_12(m1[1]), .matrix_13(m1[2]),
        .matrix_21(m1[3]), .matrix_22(m1[4]), .matrix_23(m1[5]),
        .matrix_31(m1[6]), .matrix_32(m1[7]), .matrix_33(m1[8])
    );

    always #5 clk = ~clk;

    assign win0 = {m0[0], m0[1], m0[2], m0[3], m0[4], m0[5], m0[6], m0[7], m0[8]};
    assign win1 = {m1[0], m1[1], m1[2], m1[3], m1[4], m1[5], m1[6], m1[7], m1[8]};

    // Model state: current frame pixels, next input index, remaining flush
    // clocks, next window center index and the window expected on the outputs.
    logic [7:0]  pix [N];
    int          acc_idx, flush_left, out_k, gen_k;
    logic        exp_vld;
    logic [71:0] exp_win0, exp_win1;
    logic [71:0] cap0 [N];
    logic [71:0] cap1 [N];
    int          chk_cnt, pass_cnt, cyc;
    int          win_cnt, busy_win, acc6_cyc, first_vld_cyc;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] want);
        chk_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, want);
    endtask

    function automatic logic [7:0] tap(input int r, input int c, input int mode);
        int rr = r;
        int cc = c;
        if (mode == 1) begin
            if (rr < 0)     rr = 0;
            if (rr > H - 1) rr = H - 1;
            if (cc < 0)     cc = 0;
            if (cc > W - 1) cc = W - 1;
        end else if (r < 0 || r >= H || c < 0 || c >= W) begin
            return 8'd0;
        end
        return pix[rr * W + cc];
    endfunction

    function automatic logic [71:0] ref_win(input int k, input int mode);
        logic [71:0] w = '0;
        int r = k / W;
        int c = k % W;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                w = {w[63:0], tap(r + dr, c + dc, mode)};
        return w;
    endfunction

    // One clock: drive, update the model at the edge, compare at the falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output logic acc);
        logic gen;
        rst     = r;
        din_vld = v;
        din     = d;
        acc     = !r && v && (flush_left == 0);
        @(posedge clk);
        cyc++;
        gen = 1'b0;
        if (r) begin
            acc_idx    = 0;
            flush_left = 0;
            out_k      = 0;
            exp_win0   = '0;
            exp_win1   = '0;
        end else begin
            if (flush_left > 0) begin
                gen = 1'b1;
                flush_left--;
            end
            if (acc) begin
                pix[acc_idx] = d;
                if (acc_idx == W + 1) acc6_cyc = cyc;
                if (acc_idx >= W + 1) gen = 1'b1;
                if (acc_idx == N - 1) begin
                    acc_idx    = 0;
                    flush_left = W + 1;
                end else begin
                    acc_idx++;
                end
            end
            if (gen) begin
                exp_win0 = ref_win(out_k, 0);
                exp_win1 = ref_win(out_k, 1);
                gen_k    = out_k;
                out_k    = (out_k + 1) % N;
            end
        end
        exp_vld = gen;
        @(negedge clk);
        chk("dout_vld_zero", vld0, exp_vld);
        chk("dout_vld_repl", vld1, exp_vld);
        chk("busy_zero", busy0, flush_left > 0);
        chk("busy_repl", busy1, flush_left > 0);
        chk("window_zero", win0, exp_win0);
        chk("window_repl", win1, exp_win1);
        if (vld0 && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (vld0) win_cnt++;
        if (vld0 && busy0) busy_win++;
        if (exp_vld) begin
            cap0[gen_k] = win0;
            cap1[gen_k] = win1;
        end
    endtask

    // Feed n pixels (sequential 1.. or random values) at the given duty in percent.
    task automatic run_pixels(input int n, input bit rnd_val, input int duty);
        int   got   = 0;
        int   guard = 0;
        logic a;
        logic v;
        logic [7:0] d;
        while (got < n && guard < 4000) begin
            v = (int'($urandom_range(99)) < duty);
            d = rnd_val ? 8'($urandom_range(255)) : 8'(acc_idx + 1);
            step(v, d, 1'b0, a);
            if (a) got++;
            guard++;
        end
        chk("pixel_budget", got, n);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, 8'd0, 1'b0, a);
    endtask

    task automatic clear_cap();
        for (int k = 0; k < N; k++) begin
            cap0[k] = '1;
            cap1[k] = '1;
        end
    endtask

    task automatic check_frame_seq(input string tag);
        for (int k = 0; k < N; k++) begin
            chk({tag, "_zero"}, cap0[k], ref_win(k, 0));
            chk({tag, "_repl"}, cap1[k], ref_win(k, 1));
        end
    endtask

    initial begin
        logic a;
        step(1'b0, 8'd0, 1'b1, a);
        step(1'b0, 8'd0, 1'b1, a);
        idle(2);

        // Back-to-back frame 1..12.
        clear_cap();
        win_cnt = 0; busy_win = 0; first_vld_cyc = -1; acc6_cyc = -100;
        run_pixels(N, 1'b0, 100);
        idle(W + 4);
        chk("frame_windows", win_cnt, N);
        chk("busy_windows", busy_win, W + 1);
        // The first window is on the outputs in the clock following pixel 6's edge.
        chk("first_vld_latency", first_vld_cyc, acc6_cyc);
        chk("c00_zero", cap0[0], C00_Z);
        chk("c00_repl", cap1[0], C00_R);
        chk("c11_zero", cap0[W + 1], C11);
        chk("c11_repl", cap1[W + 1], C11);
        chk("c23_zero", cap0[N - 1], C23_Z);
        chk("c23_repl", cap1[N - 1], C23_R);

        // Same frame with ~50% valid duty.
        clear_cap();
        run_pixels(N, 1'b0, 50);
        idle(W + 4);
        check_frame_seq("gap_seq");
        chk("gap_c00_zero", cap0[0], C00_Z);
        chk("gap_c23_repl", cap1[N - 1], C23_R);

        // Random frame, valid held high through FLUSH, then a 1..12 frame.
        run_pixels(N, 1'b1, 100);
        repeat (W + 1) step(1'b1, 8'hEE, 1'b0, a);
        clear_cap();
        run_pixels(N, 1'b0, 100);
        idle(W + 4);
        chk("after_flush_c00_zero", cap0[0], C00_Z);
        chk("after_flush_c00_repl", cap1[0], C00_R);
        check_frame_seq("after_flush_seq");

        // Reset after pixel 7, then a fresh frame.
        run_pixels(7, 1'b0, 100);
        step(1'b0, 8'd0, 1'b1, a);
        chk("rst_vld", vld0, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_win_zero", win0, 72'd0);
        chk("rst_win_repl", win1, 72'd0);
        step(1'b0, 8'd0, 1'b0, a);
        clear_cap();
        win_cnt = 0; busy_win = 0; first_vld_cyc = -1; acc6_cyc = -100;
        run_pixels(N, 1'b0, 100);
        idle(W + 4);
        chk("rst_frame_windows", win_cnt, N);
        chk("rst_first_vld_latency", first_vld_cyc, acc6_cyc);
        chk("rst_c00_zero", cap0[0], C00_Z);
        chk("rst_c00_repl", cap1[0], C00_R);
        chk("rst_c23_zero", cap0[N - 1], C23_Z);
        chk("rst_c23_repl", cap1[N - 1], C23_R);

        // Random values with random gaps.
        for (int f = 0; f < 3; f++) begin
            clear_cap();
            run_pixels(N, 1'b1, 60);
            idle(W + 4);
            check_frame_seq("rand_seq");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/matrix_3x3_gen.md
MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per line (>=2).
REQ-003 SHALL have parameter IMG_H, default 480, lines per frame (>=2).
REQ-004 SHALL have parameter BORDER_MODE, default 0, out-of-frame tap policy: 0 = zero, 1 = replicate nearest edge pixel.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port din_vld  input  1  input pixel strobe, raster order.
REQ-008 SHALL have port din  input  DATA_W  input pixel.
REQ-009 SHALL have port busy  output  1  high while in FLUSH; din_vld ignored.
REQ-010 SHALL have port dout_vld  output  1  window valid strobe.
REQ-011 SHALL have ports matrix_11..matrix_33  output  DATA_W each  3x3 window; matrix_RC with R = row (1 top), C = column (1 left); matrix_22 = center.

Function
REQ-012 SHALL buffer two previous lines internally (depth IMG_W each); no vendor shift-register IP.
REQ-013 SHALL track input position (in_col 0..IMG_W-1, in_row 0..IMG_H-1) and output center position (out_col, out_row); both wrap at end of line/frame.
REQ-014 SHALL emit exactly one window per frame pixel, IMG_W*IMG_H windows per frame, centers in raster order.
REQ-015 SHALL emit the window centered on linear pixel index k in the cycle after the din_vld accepting index k+IMG_W+1 (latency IMG_W+1 pixels + 1 clk).
REQ-016 SHALL hold matrix_* and deassert dout_vld in cycles with no window emitted.
REQ-017 SHALL substitute taps outside the frame (row -1, row IMG_H, col -1, col IMG_W) per BORDER_MODE; taps never wrap to the adjacent line or frame.
REQ-018 SHALL, in replicate mode, clamp row and column independently (corner tap = corner pixel).
REQ-019 SHALL implement FSM IDLE -> FILL (first accepted pixel of frame) -> RUN (accept of index IMG_W+1) -> FLUSH (accept of last pixel, index IMG_W*IMG_H-1) -> IDLE.
REQ-020 SHALL, in FLUSH, self-generate the remaining IMG_W+1 windows, one per clk, with dout_vld high each cycle.
REQ-021 SHALL drop din_vld pixels arriving while busy; no counter advances for them.
REQ-022 SHALL begin a new frame with the next din_vld after FLUSH completes; previous-frame line data SHALL not appear in any tap.
REQ-023 SHALL tolerate arbitrary gaps in din_vld in FILL/RUN with no output change.
REQ-024 SHALL produce no arithmetic on pixel values; taps are pure copies, DATA_W wide.

Reset
REQ-025 SHALL on rst force FSM to IDLE, all counters to 0, busy=0, dout_vld=0, matrix_* =0, in the cycle after rst sampled high.
REQ-026 SHALL on rst mid-frame abandon the frame; the next din_vld after rst low is pixel (0,0) of a new frame.
REQ-027 SHALL not require line-buffer memory to be cleared; border logic masks stale contents.

Verification
REQ-028 SHALL cover: IMG_W=4, IMG_H=3, BORDER_MODE=0, din=1..12 back-to-back -> first dout_vld 1 clk after pixel 6, center(0,0) = 0,0,0/0,1,2/0,5,6; 12 windows total, last 5 with busy=1.
REQ-029 SHALL cover: same stimulus, BORDER_MODE=1 -> center(0,0) = 1,1,2/1,1,2/5,5,6; center(2,3) = 7,8,8/11,12,12/11,12,12.
REQ-030 SHALL cover: interior center(1,1) either mode -> 1,2,3/5,6,7/9,10,11; BORDER_MODE=0 center(2,3) = 7,8,0/11,12,0/0,0,0.
REQ-031 SHALL cover: random din_vld gaps (50% duty) -> window sequence identical to back-to-back run.
REQ-032 SHALL cover: din_vld held high during FLUSH -> those pixels dropped; next frame after FLUSH yields correct center(0,0).
REQ-033 SHALL cover: rst asserted after pixel 7 -> outputs 0 next clk; fresh frame 1..12 reproduces REQ-028 results exactly.
